// File: rtl/game_sequencer.sv
// game_sequencer: round/symbol sequencing FSM for the memory game (pick, show, collect guesses).
// Define GAME_TIMEOUT_EN to send an idle player to LOSE after TIMEOUT_TICKS cycles in INPUT.
module game_sequencer #(
    parameter int unsigned MAX_ROUNDS    = 6,
    parameter int unsigned SHOW_TICKS    = 25000000,
    parameter int unsigned GAP_TICKS     = 6250000,
    parameter int unsigned WIN_TICKS     = 25000000,
    parameter int unsigned TIMEOUT_TICKS = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       six_rounds,
    input  logic [3:0] rand_sym,
    input  logic       guess_valid,
    input  logic [3:0] guess,
    output logic [3:0] disp_sym,
    output logic       disp_valid,
    output logic [2:0] round,
    output logic [2:0] seq_idx,
    output logic       win,
    output logic       lose,
    output logic       game_over
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PICK  = 3'd1;
    localparam logic [2:0] S_SHOW  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_INPUT = 3'd4;
    localparam logic [2:0] S_RWIN  = 3'd5;
    localparam logic [2:0] S_LOSE  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [3:0] BLANK       = 4'hF;
    localparam logic [2:0] FULL_TARGET = (MAX_ROUNDS >= 6) ? 3'd6 : 3'(MAX_ROUNDS);

    if (MAX_ROUNDS < 4 || MAX_ROUNDS > 6 || TIMEOUT_TICKS == 0) begin : g_bad_cfg
        $error("game_sequencer: MAX_ROUNDS must be 4..6 and TIMEOUT_TICKS nonzero");
    end

    logic [2:0]  state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic [2:0]  seq_q, seq_d;
    logic [2:0]  round_q, round_d;
    logic [2:0]  target_q, target_d;
    logic [3:0]  store_q [MAX_ROUNDS];
    logic [3:0]  store_d [MAX_ROUNDS];

    logic [3:0]  cur_sym;
    logic        sym_fresh;
    logic [2:0]  last_idx;
    logic        at_last;
    logic        guess_ok;

    logic [3:0]  disp_sym_q;
    logic        disp_valid_q;
    logic [2:0]  round_out_q;
    logic [2:0]  seq_out_q;
    logic        win_q;
    logic        lose_q;
    logic        over_q;

    assign last_idx = round_q - 3'd1;
    assign at_last  = (seq_q == last_idx);
    assign guess_ok = (guess <= 4'd5) && (guess == cur_sym);

    // Store is walked by loop so the index width never has to match MAX_ROUNDS.
    always_comb begin
        cur_sym   = BLANK;
        sym_fresh = (rand_sym <= 4'd5);
        for (int unsigned i = 0; i < MAX_ROUNDS; i++) begin
            if (3'(i) == seq_q) cur_sym = store_q[i];
            if (store_q[i] == rand_sym) sym_fresh = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        seq_d    = seq_q;
        round_d  = round_q;
        target_d = target_q;
        store_d  = store_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int unsigned i = 0; i < MAX_ROUNDS; i++) store_d[i] = BLANK;
                    round_d  = 3'd1;
                    target_d = six_rounds ? FULL_TARGET : 3'd4;
                    state_d  = S_PICK;
                end
            end
            S_PICK: begin
                if (sym_fresh) begin
                    for (int unsigned i = 0; i < MAX_ROUNDS; i++) begin
                        if (3'(i) == last_idx) store_d[i] = rand_sym;
                    end
                    seq_d   = '0;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (tick_q == SHOW_TICKS - 1) state_d = S_GAP;
                else tick_d = tick_q + 32'd1;
            end
            S_GAP: begin
                if (tick_q == GAP_TICKS - 1) begin
                    if (at_last) begin
                        seq_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        seq_d   = seq_q + 3'd1;
                        state_d = S_SHOW;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            S_INPUT: begin
                // A guess in the timeout cycle wins over the timeout.
                if (guess_valid) begin
                    if (guess_ok) begin
                        tick_d = '0;
                        if (at_last) state_d = S_RWIN;
                        else seq_d = seq_q + 3'd1;
                    end else begin
                        state_d = S_LOSE;
                    end
                end
`ifdef GAME_TIMEOUT_EN
                else if (tick_q == TIMEOUT_TICKS - 1) state_d = S_LOSE;
                else tick_d = tick_q + 32'd1;
`endif
            end
            S_RWIN: begin
                if (tick_q == WIN_TICKS - 1) begin
                    if (round_q == target_q) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 3'd1;
                        state_d = S_PICK;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            S_LOSE: begin
                if (start) begin
                    seq_d   = '0;
                    state_d = S_SHOW;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) tick_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            seq_q    <= '0;
            round_q  <= '0;
            target_q <= 3'd4;
            for (int unsigned i = 0; i < MAX_ROUNDS; i++) store_q[i] <= BLANK;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            seq_q    <= seq_d;
            round_q  <= round_d;
            target_q <= target_d;
            store_q  <= store_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sym_q   <= BLANK;
            disp_valid_q <= 1'b0;
            round_out_q  <= '0;
            seq_out_q    <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            disp_sym_q   <= (state_q == S_SHOW) ? cur_sym : BLANK;
            disp_valid_q <= (state_q == S_SHOW);
            round_out_q  <= round_q;
            seq_out_q    <= seq_q;
            win_q        <= (state_q == S_RWIN) || (state_q == S_DONE);
            lose_q       <= (state_q == S_LOSE);
            over_q       <= (state_q == S_DONE);
        end
    end

    assign disp_sym   = disp_sym_q;
    assign disp_valid = disp_valid_q;
    assign round      = round_out_q;
    assign seq_idx    = seq_out_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign game_over  = over_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a display scoreboard plus per-scenario tasks.
// Run with GAME_TIMEOUT_EN defined to exercise the guess timeout instead of the no-timeout case.
module tb_game_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, six_rounds, guess_valid;
    logic [3:0] rand_sym, guess, disp_sym;
    logic       disp_valid, win, lose, game_over;
    logic [2:0] round, seq_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q [$];   // display symbols expected, in order
    logic [3:0] mstore [$];  // bench model of the sequence store

    game_sequencer #(
        .MAX_ROUNDS   (6),
        .SHOW_TICKS   (4),
        .GAP_TICKS    (2),
        .WIN_TICKS    (3),
        .TIMEOUT_TICKS(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .six_rounds (six_rounds),
        .rand_sym   (rand_sym),
        .guess_valid(guess_valid),
        .guess      (guess),
        .disp_sym   (disp_sym),
        .disp_valid (disp_valid),
        .round      (round),
        .seq_idx    (seq_idx),
        .win        (win),
        .lose       (lose),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Display monitor: each shown burst must match the next expected symbol and last 4 cycles.
    logic       prev_valid = 1'b0;
    int         burst_len  = 0;
    logic [3:0] burst_sym  = 4'h0;
    logic [3:0] exp_sym;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            burst_len  = 0;
        end else begin
            if (disp_valid === 1'b1) begin
                if (!prev_valid) begin
                    burst_len = 1;
                    burst_sym = disp_sym;
                end else begin
                    burst_len++;
                end
            end else if (prev_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL display_unexpected: shown sym %0d, no display expected", burst_sym);
                end else begin
                    exp_sym = exp_q.pop_front();
                    if (burst_sym !== exp_sym || burst_len != 4) begin
                        n_fail++;
                        $display("FAIL display_burst: sym %0d for %0d cycles, required sym %0d for 4 cycles",
                                 burst_sym, burst_len, exp_sym);
                    end
                end
                n_checks++;
                if (disp_sym !== 4'hF) begin
                    n_fail++;
                    $display("FAIL display_blank: disp_sym %h in gap, required f", disp_sym);
                end
            end
            prev_valid = (disp_valid === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_guess(input logic [3:0] g);
        @(negedge clk);
        guess       = g;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic push_seq();
        foreach (mstore[i]) exp_q.push_back(mstore[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        mstore.delete();
    endtask

    task automatic wait_shown(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_playback: %0d symbols still pending after %0d cycles, required 0",
                     tag, exp_q.size(), k);
            exp_q.delete();
        end
        tick(3);
    endtask

    // Enters every symbol of the model sequence; the last one must raise win after edge N+1.
    task automatic guess_round(input string tag);
        for (int i = 0; i < mstore.size() - 1; i++) send_guess(mstore[i]);
        send_guess(mstore[mstore.size() - 1]);
        n_checks++;
        if (win !== 1'b0 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency_early: win=%b lose=%b, required 0 0", tag, win, lose);
        end
        @(negedge clk);
        n_checks++;
        if (win !== 1'b1 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_win: win=%b lose=%b, required 1 0", tag, win, lose);
        end
    endtask

    task automatic finish_round(input string tag, input logic [3:0] next_sym);
        int cnt = 1;
        rand_sym = next_sym;
        mstore.push_back(next_sym);
        push_seq();
        while (win === 1'b1 && cnt < 20) begin
            @(negedge clk);
            if (win === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL %s_win_len: win held %0d cycles, required 3", tag, cnt);
        end
        n_checks++;
        if (round !== 3'(mstore.size()) || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_next_round: round=%0d game_over=%b, required %0d 0",
                     tag, round, game_over, mstore.size());
        end
    endtask

    task automatic finish_game(input string tag, input logic [2:0] target);
        n_checks++;
        if (game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_over_early: game_over=%b, required 0", tag, game_over);
        end
        tick(4);
        n_checks++;
        if (win !== 1'b1 || game_over !== 1'b1 || round !== target || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: win=%b game_over=%b round=%0d lose=%b, required 1 1 %0d 0",
                     tag, win, game_over, round, lose, target);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        start = 1'b0; guess_valid = 1'b0; guess = 4'h0; six_rounds = 1'b0; rand_sym = 4'h7;
        do_reset();
        n_checks++;
        if (round !== 3'd0 || disp_sym !== 4'hF || disp_valid !== 1'b0 || seq_idx !== 3'd0 ||
            win !== 1'b0 || lose !== 1'b0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: round=%0d disp=%h dv=%b seq=%0d win=%b lose=%b over=%b, required 0 f 0 0 0 0 0",
                     round, disp_sym, disp_valid, seq_idx, win, lose, game_over);
        end
        tick(3);
        n_checks++;
        if (round !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_round: round=%0d, required 0", round);
        end
        pulse_start();
        tick(1);
        n_checks++;
        if (round !== 3'd1) begin
            n_fail++;
            $display("FAIL start_round: round=%0d, required 1", round);
        end
        tick(4);
        n_checks++;
        if (disp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pick_reject: disp_valid=%b with rand_sym 7, required 0", disp_valid);
        end
        rand_sym = 4'd2;
        mstore.push_back(4'd2);
        push_seq();
        while (disp_valid !== 1'b1 && n < 8) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (disp_valid !== 1'b1 || n > 6) begin
            n_fail++;
            $display("FAIL pick_exit: display began after %0d cycles, required at most 6", n);
        end
    endtask

    task automatic test_round1_playback();
        wait_shown("r1");
        guess_round("r1");
        finish_round("r1", 4'd5);
        wait_shown("r2");
    endtask

    task automatic test_uniqueness();
        int seen = 0;
        do_reset();
        six_rounds = 1'b0;
        rand_sym   = 4'd3;
        mstore.push_back(4'd3);
        push_seq();
        pulse_start();
        wait_shown("uniq_r1");
        guess_round("uniq_r1");
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (disp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0 || round !== 3'd2 || win !== 1'b0) begin
            n_fail++;
            $display("FAIL uniq_stall: shown %0d cycles round=%0d win=%b, required 0 2 0", seen, round, win);
        end
        rand_sym = 4'd4;
        mstore.push_back(4'd4);
        push_seq();
        wait_shown("uniq_r2");
    endtask

    task automatic test_wrong_retry();
        send_guess(mstore[0]);
        send_guess(4'd0);
        n_checks++;
        if (lose !== 1'b0) begin
            n_fail++;
            $display("FAIL lose_latency_early: lose=%b, required 0", lose);
        end
        tick(1);
        n_checks++;
        if (lose !== 1'b1 || win !== 1'b0 || round !== 3'd2) begin
            n_fail++;
            $display("FAIL lose_state: lose=%b win=%b round=%0d, required 1 0 2", lose, win, round);
        end
        tick(5);
        n_checks++;
        if (lose !== 1'b1 || disp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lose_hold: lose=%b disp_valid=%b, required 1 0", lose, disp_valid);
        end
        push_seq();
        pulse_start();
        tick(1);
        n_checks++;
        if (lose !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_clear: lose=%b, required 0", lose);
        end
        wait_shown("retry");
        guess_round("retry");
        finish_round("retry", 4'd1);
    endtask

    task automatic test_length();
        logic [3:0] nxt [5] = '{4'd0, 4'd4, 4'd1, 4'd3, 4'd2};
        six_rounds = 1'b1;
        send_guess(4'd5);
        pulse_start();
        wait_shown("r3");
        guess_round("r3");
        finish_round("r3", 4'd0);
        six_rounds = 1'b0;
        wait_shown("r4");
        guess_round("r4");
        finish_game("four", 3'd4);

        six_rounds = 1'b1;
        rand_sym   = 4'd5;
        mstore.delete();
        mstore.push_back(4'd5);
        push_seq();
        pulse_start();
        tick(1);
        n_checks++;
        if (round !== 3'd1 || game_over !== 1'b0 || win !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_from_done: round=%0d over=%b win=%b, required 1 0 0", round, game_over, win);
        end
        for (int i = 0; i < 5; i++) begin
            wait_shown("six");
            guess_round("six");
            finish_round("six", nxt[i]);
            if (i == 1) six_rounds = 1'b0;
        end
        wait_shown("six_r6");
        guess_round("six_r6");
        finish_game("six", 3'd6);
    endtask

`ifdef GAME_TIMEOUT_EN
    task automatic wait_burst_end();
        int k = 0;
        while (disp_valid !== 1'b1 && k < 100) begin tick(1); k++; end
        while (disp_valid === 1'b1 && k < 100) begin tick(1); k++; end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        rand_sym = 4'd2;
        mstore.push_back(4'd2);
        push_seq();
        pulse_start();
        wait_burst_end();
        while (lose !== 1'b1 && n < 30) begin tick(1); n++; end
        n_checks++;
        if (n != 12) begin
            n_fail++;
            $display("FAIL timeout_lose: lose seen %0d cycles after display end, required 12", n);
        end
        push_seq();
        pulse_start();
        wait_burst_end();
        tick(9);
        send_guess(4'd2);
        n_checks++;
        if (win !== 1'b0 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_early: win=%b lose=%b, required 0 0", win, lose);
        end
        tick(1);
        n_checks++;
        if (win !== 1'b1 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_guess: win=%b lose=%b, required 1 0", win, lose);
        end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        rand_sym = 4'd1;
        mstore.push_back(4'd1);
        push_seq();
        pulse_start();
        wait_shown("no_timeout");
        tick(30);
        n_checks++;
        if (lose !== 1'b0 || win !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: lose=%b win=%b, required 0 0", lose, win);
        end
        guess_round("no_timeout");
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round1_playback();
        test_uniqueness();
        test_wrong_retry();
        test_length();
`ifdef GAME_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
